// File: rtl/rv_pkg.sv
// Shared RV32I encoding constants and the abstract op enumeration.
// Used by the instruction encoder and the control unit decode path.
package rv_pkg;

   localparam logic [6:0] OPC_R     = 7'b0110011;
   localparam logic [6:0] OPC_I     = 7'b0010011;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_W   = 3'b010;
   localparam logic [2:0] F3_XOR = 3'b100;
   localparam logic [2:0] F3_AND = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_SUB  = 7'b0100000;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_XOR  = 4'd3,
      OP_SLL  = 4'd4,
      OP_SW   = 4'd5,
      OP_LUI  = 4'd6,
      OP_ADDI = 4'd7,
      OP_ANDI = 4'd8,
      OP_LW   = 4'd9
   } op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } enc_state_e;

   // True when imm fits a signed 12-bit field.
   function automatic logic imm12_ok(input logic [31:0] imm);
      return (&imm[31:11]) | ~(|imm[31:11]);
   endfunction

endpackage

// File: rtl/rv_instr_pack.sv
// Combinational RV32I field packer: op plus operand fields to machine
// word, with a legality flag for unknown ops and out-of-range immediates.
module rv_instr_pack
   import rv_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic        legal
);

   logic i_ok;

   assign i_ok = imm12_ok(imm);

   always_comb begin
      word  = '0;
      legal = 1'b0;
      case (op)
         OP_ADD: begin
            word  = {F7_BASE, rs2, rs1, F3_ADD, rd, OPC_R};
            legal = 1'b1;
         end
         OP_SUB: begin
            word  = {F7_SUB, rs2, rs1, F3_ADD, rd, OPC_R};
            legal = 1'b1;
         end
         OP_AND: begin
            word  = {F7_BASE, rs2, rs1, F3_AND, rd, OPC_R};
            legal = 1'b1;
         end
         OP_XOR: begin
            word  = {F7_BASE, rs2, rs1, F3_XOR, rd, OPC_R};
            legal = 1'b1;
         end
         OP_SLL: begin
            word  = {F7_BASE, rs2, rs1, F3_SLL, rd, OPC_R};
            legal = 1'b1;
         end
         OP_SW: begin
            word  = {imm[11:5], rs2, rs1, F3_W, imm[4:0], OPC_STORE};
            legal = i_ok;
         end
         OP_LUI: begin
            word  = {imm[19:0], rd, OPC_LUI};
            legal = ~(|imm[31:20]);
         end
         OP_ADDI: begin
            word  = {imm[11:0], rs1, F3_ADD, rd, OPC_I};
            legal = i_ok;
         end
         OP_ANDI: begin
            word  = {imm[11:0], rs1, F3_AND, rd, OPC_I};
            legal = i_ok;
         end
         OP_LW: begin
            word  = {imm[11:0], rs1, F3_W, rd, OPC_LOAD};
            legal = i_ok;
         end
         default: begin
            word  = '0;
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/rv_instr_encoder.sv
// Sequential RV32I encoder feeding the instruction memory write port.
// Define RV_ENC_ERR_CNT_EN to add the saturating err_cnt output.
module rv_instr_encoder
   import rv_pkg::*;
#(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned BASE_ADDR = 0
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        op,
   input  logic [4:0]        rd,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [31:0]       imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] addr,
`ifdef RV_ENC_ERR_CNT_EN
   output logic [7:0]        err_cnt,
`endif
   output logic              err
);

   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

   enc_state_e  state_q, state_d;
   logic [31:0] word;
   logic        legal;
   logic        take;
   logic        bad;
   logic        pop;

   rv_instr_pack u_pack (
      .op    (op),
      .rd    (rd),
      .rs1   (rs1),
      .rs2   (rs2),
      .imm   (imm),
      .word  (word),
      .legal (legal)
   );

   assign take = (state_q == ST_IDLE) & in_valid & legal & ~clear;
   assign bad  = (state_q == ST_IDLE) & in_valid & ~legal & ~clear;
   assign pop  = (state_q == ST_HOLD) & out_ready & ~clear;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (clear)     state_d = ST_IDLE;
      else if (take) state_d = ST_HOLD;
      else if (pop)  state_d = ST_IDLE;
   end

   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_HOLD);
   end

   // Address wraps naturally at 2^ADDR_W, not back to BASE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr <= '0;
         addr  <= BASE;
         err   <= 1'b0;
      end else begin
         err <= bad;
         if (clear) begin
            instr <= '0;
            addr  <= BASE;
         end else begin
            if (take) instr <= word;
            if (pop)  addr  <= addr + STEP;
         end
      end
   end

`ifdef RV_ENC_ERR_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    err_cnt <= '0;
      else if (clear)                err_cnt <= '0;
      else if (bad && err_cnt != '1) err_cnt <= err_cnt + 8'd1;
   end
`endif

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Directed self-checking bench for rv_instr_encoder (ADDR_W=4).
// Covers encodings, backpressure, illegal requests, wrap, clear, reset.
module tb_rv_instr_encoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  op = '0;
   logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
   logic [31:0] imm = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] instr;
   logic [3:0]  addr;
   logic        err;
`ifdef RV_ENC_ERR_CNT_EN
   logic [7:0]  err_cnt;
`endif

   int total = 0;
   int passed = 0;
   logic [3:0] exp_addr = 4'h0;

   always #5 clk = ~clk;

   rv_instr_encoder #(.ADDR_W(4), .BASE_ADDR(0)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .rd        (rd),
      .rs1       (rs1),
      .rs2       (rs2),
      .imm       (imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .instr     (instr),
      .addr      (addr),
`ifdef RV_ENC_ERR_CNT_EN
      .err_cnt   (err_cnt),
`endif
      .err       (err)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Present one request for a single cycle; returns at the next negedge.
   task automatic push(input logic [3:0] o, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2,
                       input logic [31:0] im);
      op = o; rd = d; rs1 = s1; rs2 = s2; imm = im;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic pop();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic word(input string tag, input logic [3:0] o,
                       input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [31:0] im,
                       input logic [31:0] exp_instr);
      push(o, d, s1, s2, im);
      chk({tag, ".valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".instr"}, instr, exp_instr);
      chk({tag, ".addr"}, 32'(addr), 32'(exp_addr));
      pop();
      exp_addr = exp_addr + 4'd4;
      chk({tag, ".done"}, 32'(out_valid), 32'd0);
      chk({tag, ".next"}, 32'(addr), 32'(exp_addr));
   endtask

   task automatic bad(input string tag, input logic [3:0] o,
                      input logic [31:0] im);
      push(o, 5'd1, 5'd1, 5'd1, im);
      chk({tag, ".err"}, 32'(err), 32'd1);
      chk({tag, ".valid"}, 32'(out_valid), 32'd0);
      chk({tag, ".ready"}, 32'(in_ready), 32'd1);
      chk({tag, ".addr"}, 32'(addr), 32'(exp_addr));
      @(negedge clk);
      chk({tag, ".errlo"}, 32'(err), 32'd0);
      chk({tag, ".valid2"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      #12;
      chk("rst.in_ready", 32'(in_ready), 32'd1);
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.instr", instr, 32'h0);
      chk("rst.err", 32'(err), 32'd0);
      chk("rst.addr", 32'(addr), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      word("add", 4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3);
      word("sub", 4'd1, 5'd3, 5'd1, 5'd2, 32'd0, 32'h402081B3);

      push(4'd5, 5'd0, 5'd2, 5'd5, 32'hFFFFFFFC);
      for (int i = 0; i < 5; i++) begin
         chk("sw.instr", instr, 32'hFE512E23);
         chk("sw.in_ready", 32'(in_ready), 32'd0);
         chk("sw.valid", 32'(out_valid), 32'd1);
         chk("sw.addr", 32'(addr), 32'h8);
         @(negedge clk);
      end
      pop();
      exp_addr = 4'hC;
      chk("sw.next", 32'(addr), 32'hC);

      bad("addi800", 4'd7, 32'h00000800);
      bad("op12", 4'd12, 32'd0);
`ifdef RV_ENC_ERR_CNT_EN
      chk("err_cnt2", 32'(err_cnt), 32'd2);
`endif
      bad("luihi", 4'd6, 32'h00100000);
`ifdef RV_ENC_ERR_CNT_EN
      chk("err_cnt3", 32'(err_cnt), 32'd3);
`endif

      word("lui", 4'd6, 5'd7, 5'd0, 5'd0, 32'h00012345, 32'h123453B7);
      chk("wrap.addr", 32'(addr), 32'h0);
      word("lw", 4'd9, 5'd4, 5'd0, 5'd0, 32'd8, 32'h00802203);
      word("and", 4'd2, 5'd5, 5'd6, 5'd7, 32'd0, 32'h007372B3);
      word("xor", 4'd3, 5'd1, 5'd2, 5'd3, 32'd0, 32'h003140B3);
      word("sll", 4'd4, 5'd1, 5'd1, 5'd1, 32'd0, 32'h001090B3);
      word("andi", 4'd8, 5'd2, 5'd3, 5'd0, 32'hFFFFFFFF, 32'hFFF1F113);

      push(4'd7, 5'd1, 5'd0, 5'd0, 32'd5);
      chk("clr.pre", instr, 32'h00500093);
      chk("clr.preaddr", 32'(addr), 32'h4);
      clear = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clear = 1'b0;
      out_ready = 1'b0;
      chk("clr.valid", 32'(out_valid), 32'd0);
      chk("clr.addr", 32'(addr), 32'h0);
      chk("clr.ready", 32'(in_ready), 32'd1);
`ifdef RV_ENC_ERR_CNT_EN
      chk("clr.err_cnt", 32'(err_cnt), 32'd0);
`endif
      exp_addr = 4'h0;
      word("postclr", 4'd7, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093);

      push(4'd0, 5'd3, 5'd1, 5'd2, 32'd0);
      chk("mid.valid", 32'(out_valid), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid.valid0", 32'(out_valid), 32'd0);
      chk("mid.instr", instr, 32'h0);
      chk("mid.addr", 32'(addr), 32'h0);
      chk("mid.ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/rv_instr_encoder.md
Name: rv_instr_encoder

Overview:
- Sequential RV32I instruction encoder; the inverse of the control-unit decode path.
- Accepts an abstract operation plus operand fields over a valid/ready handshake and emits the 32-bit machine word. Each word is paired with a byte address for loading instruction memory.
- Covers exactly the decoder's instruction set: ADD, SUB, AND, XOR, SLL, SW, LUI, ADDI, ANDI, LW.
- Sits between the test/program loader and the instruction memory write port.

Parameters:
- ADDR_W, 8, width of the output byte address; the address wraps modulo 2^ADDR_W.
- BASE_ADDR, 0, address loaded on reset and on clear; must be a multiple of 4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous; returns the FSM to IDLE, reloads the address, drops any held word.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request.
- op  in  4  operation: 0 ADD, 1 SUB, 2 AND, 3 XOR, 4 SLL, 5 SW, 6 LUI, 7 ADDI, 8 ANDI, 9 LW; 10..15 illegal.
- rd, rs1, rs2  in  5 each  register indices.
- imm  in  32  immediate. Sign-extended value for I/S ops; for LUI, the upper-20 value in imm[19:0].
- out_valid  out  1  instr and addr are valid.
- out_ready  in  1  consumer accepts the word.
- instr  out  32  encoded instruction.
- addr  out  ADDR_W  byte address of instr.
- err  out  1  one-cycle pulse: request rejected.

Behaviour:
- Reset values: in_ready=1, out_valid=0, instr=0, err=0, addr=BASE_ADDR, state IDLE.
- FSM has two states: IDLE and HOLD.
- IDLE: in_ready=1.
  - On in_valid and a legal request: register the encoded word and go to HOLD.
  - out_valid rises on the next cycle, so latency is 1 cycle from accept.
- HOLD: in_ready=0, out_valid=1.
  - instr and addr stay stable until out_ready.
  - On out_ready: addr += 4 (wrapping modulo 2^ADDR_W) and return to IDLE.
  - No combinational in-to-out path; maximum throughput is one word per 2 cycles.
- Encodings (funct7 | rs2 | rs1 | funct3 | rd | opcode):
  - R-type, opcode 0110011: ADD f7 0000000/f3 000; SUB f7 0100000/f3 000; AND 0000000/111; XOR 0000000/100; SLL 0000000/001.
  - I-type: ADDI opcode 0010011 f3 000; ANDI opcode 0010011 f3 111; LW opcode 0000011 f3 010; imm[11:0] goes in bits 31:20.
  - SW: opcode 0100011 f3 010; bits 31:25 = imm[11:5], bits 11:7 = imm[4:0].
  - LUI: opcode 0110111; bits 31:12 = imm[19:0].
  - Unused fields are driven to 0.
- Legality (checked in IDLE on in_valid):
  - op must be 0..9.
  - I/S ops: imm[31:11] must be all-0 or all-1.
  - LUI: imm[31:20] must be 0.
  - An illegal request is accepted (consumed), err pulses on the following cycle, nothing is produced, addr is unchanged, and the FSM stays in IDLE.
- Register fields need no check; rd=0 is legal.
- clear has priority over every other event in the same cycle. A word held in HOLD is discarded without advancing addr.
- Reset asserted mid-HOLD: outputs return to reset values immediately (asynchronous).
- Address wrap: at addr = 2^ADDR_W-4, acceptance of the word wraps addr to 0, not to BASE_ADDR.

Optional Feature:
- Macro: RV_ENC_ERR_CNT_EN.
- Defined:
  - Adds output err_cnt (8 bits), counting illegal requests.
  - Saturates at 255.
  - Cleared by reset and by clear.
- Undefined: the port and the counter are absent; err behaviour is unchanged.

Decomposition:
- Shared package rv_pkg holds:
  - opcode constants OPC_R=0110011, OPC_I=0010011, OPC_LOAD=0000011, OPC_STORE=0100011, OPC_LUI=0110111;
  - funct3/funct7 constants;
  - the 4-bit op enumeration.
- The control unit reuses the same constants.
- One sub-module: rv_instr_pack, a combinational field packer from op/fields/imm to word plus a legal flag. The top holds the FSM, the registers, the address counter and the optional counter.

Test Plan:
- ADD rd=3, rs1=1, rs2=2, out_ready=1 -> instr 0x002081B3 at addr 0x00 one cycle after accept; addr becomes 0x04.
- SUB rd=3, rs1=1, rs2=2 -> instr 0x402081B3.
- SW rs2=5, rs1=2, imm=-4 with out_ready held 0 for 5 cycles -> instr 0xFE512E23 stable, in_ready=0 throughout; a single addr increment on release.
- Illegal cases -> err pulses, no out_valid, addr unchanged:
  - ADDI imm=0x800;
  - op=12;
  - with RV_ENC_ERR_CNT_EN, err_cnt=2 afterwards.
- LUI rd=7, imm=0x12345 -> instr 0x123453B7. Then LW rd=4, rs1=0, imm=8 -> instr 0x00802203.
- Wrap and clear:
  - ADDR_W=4: the fourth word at addr 0xC, then the next word at 0x0.
  - clear asserted during HOLD -> out_valid=0 next cycle, addr=BASE_ADDR.
